uart_loader: RTL and testbench

// Packet parser downstream of the UART RX buffer. It pulls bytes through the read_ptr/read_valid/uart_DO interface.

---
 rtl/uart_loader_if.sv | 32 +++
 rtl/uart_loader.sv | 174 +++++++++++++++++
 tb/tb_uart_loader.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_loader_if.sv
// Signal bundle between the frame loader, the UART RX/TX buffers and the target memory write port.
interface uart_loader_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic [AW-1:0] read_ptr;
  logic          read_valid;
  logic [DW-1:0] uart_DO;
  logic          rx_clear;
  logic [DW-1:0] tx_DI;
  logic [AW-1:0] send_ptr;
  logic          tx_clear;
  logic          send_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          busy;
  logic          frame_ok;
  logic          frame_err;

  modport master (
    output read_ptr, rx_clear, tx_DI, send_ptr, tx_clear,
    output mem_addr, mem_wdata, mem_we, busy, frame_ok, frame_err,
    input  read_valid, uart_DO, send_done
  );

  modport slave (
    input  read_ptr, rx_clear, tx_DI, send_ptr, tx_clear,
    input  mem_addr, mem_wdata, mem_we, busy, frame_ok, frame_err,
    output read_valid, uart_DO, send_done
  );
endinterface

// File: rtl/uart_loader.sv
// Host frame loader: parses SYNC/ADDR/LEN/PAYLOAD/CHK frames from the UART RX buffer,
// streams the payload into a byte-wide memory write port and queues an ACK/NAK reply.
module uart_loader #(
  parameter logic [7:0]  SYNC_BYTE    = 8'h55,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15,
  parameter int unsigned RD_WAIT      = 2,
  parameter int unsigned TIMEOUT_CLKS = 2147700
) (
  input logic           clk,
  input logic           rst_n,
  uart_loader_if.master bus
);
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 9;
  localparam int unsigned RW = $clog2(RD_WAIT + 2);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [2:0] {CLEAR, HUNT, HDR, DATA, CHK, RESP} state_t;

  state_t        state;
  logic          pend;
  logic [RW-1:0] rd_cnt;
  logic [TW-1:0] tmo;
  logic [1:0]    hdr_idx;
  logic [AW-1:0] addr;
  logic [CW-1:0] cnt;
  logic [DW-1:0] sum;
  logic [DW-1:0] reply;
  logic          resp_ph;

  logic          fetch_c;
  logic          got_c;
  logic          tmo_on_c;
  logic          tmo_hit_c;
  logic [DW-1:0] byte_c;

  // Byte-fetch qualifiers shared by every read state
  always_comb begin
    fetch_c   = (state == HUNT) || (state == HDR) || (state == DATA) || (state == CHK);
    tmo_on_c  = (state == HDR) || (state == DATA) || (state == CHK);
    got_c     = fetch_c && pend && (rd_cnt == RW'(RD_WAIT));
    tmo_hit_c = tmo_on_c && !got_c && (tmo == TW'(TIMEOUT_CLKS - 1));
    byte_c    = bus.uart_DO;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= CLEAR;
      pend          <= 1'b0;
      rd_cnt        <= '0;
      tmo           <= '0;
      hdr_idx       <= '0;
      addr          <= '0;
      cnt           <= '0;
      sum           <= '0;
      reply         <= '0;
      resp_ph       <= 1'b0;
      bus.read_ptr  <= '0;
      bus.rx_clear  <= 1'b0;
      bus.tx_DI     <= '0;
      bus.send_ptr  <= '0;
      bus.tx_clear  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.rx_clear  <= 1'b0;
      bus.tx_clear  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;

      // While rx_clear is still out, read_valid reflects the stale buffer fill level
      if (fetch_c) begin
        if (!pend) begin
          if (bus.read_valid && !bus.rx_clear) begin
            pend   <= 1'b1;
            rd_cnt <= RW'(1);
          end
        end else if (!got_c) begin
          rd_cnt <= rd_cnt + RW'(1);
        end else begin
          pend         <= 1'b0;
          rd_cnt       <= '0;
          bus.read_ptr <= bus.read_ptr + AW'(1);
        end
      end

      if (tmo_on_c && !got_c) tmo <= tmo + TW'(1);
      else                    tmo <= '0;

      if (tmo_hit_c) begin
        bus.frame_err <= 1'b1;
        pend          <= 1'b0;
        rd_cnt        <= '0;
        tmo           <= '0;
        state         <= CLEAR;
      end else begin
        case (state)
          CLEAR: begin
            bus.rx_clear <= 1'b1;
            bus.read_ptr <= '0;
            if (bus.send_done && (bus.send_ptr != '0)) begin
              bus.tx_clear <= 1'b1;
              bus.send_ptr <= '0;
            end
            bus.busy <= 1'b0;
            state    <= HUNT;
          end
          HUNT: if (got_c) begin
            bus.busy <= 1'b1;
            hdr_idx  <= '0;
            state    <= (byte_c == SYNC_BYTE) ? HDR : CLEAR;
          end
          HDR: if (got_c) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd0: begin
                addr[15:8] <= byte_c;
                sum        <= byte_c;
              end
              2'd1: begin
                addr[7:0] <= byte_c;
                sum       <= sum + byte_c;
              end
              default: begin
                cnt   <= (byte_c == '0) ? CW'(256) : CW'(byte_c);
                sum   <= sum + byte_c;
                state <= DATA;
              end
            endcase
          end
          DATA: if (got_c) begin
            bus.mem_addr  <= addr;
            bus.mem_wdata <= byte_c;
            bus.mem_we    <= 1'b1;
            addr          <= addr + AW'(1);
            sum           <= sum + byte_c;
            cnt           <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= CHK;
          end
          CHK: if (got_c) begin
            if (DW'(sum + byte_c) == '0) begin
              reply        <= ACK_BYTE;
              bus.frame_ok <= 1'b1;
            end else begin
              reply         <= NAK_BYTE;
              bus.frame_err <= 1'b1;
            end
            resp_ph <= 1'b0;
            state   <= RESP;
          end
          RESP: begin
            // Present the byte first, commit it with the pointer bump one clk later
            if (!resp_ph) begin
              bus.tx_DI <= reply;
              resp_ph   <= 1'b1;
            end else begin
              bus.send_ptr <= bus.send_ptr + AW'(1);
              resp_ph      <= 1'b0;
              state        <= CLEAR;
            end
          end
          default: state <= CLEAR;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: RX buffer model fed from a host byte stream, monitors for
// memory writes, replies and pulses, and one task per scenario with hand-computed expectations.
module tb_uart_loader;
  localparam int unsigned TO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_loader_if bus();
  uart_loader #(.TIMEOUT_CLKS(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Host byte stream (written only by the initial block)
  logic [7:0] hs [0:2047];
  int         hs_len = 0;
  logic [7:0] fq [$];

  // RX buffer model with registered read
  logic [7:0]  rxm [0:1023];
  logic [15:0] wr = '0;
  int          hs_rd = 0;
  assign bus.read_valid = (bus.read_ptr < wr);
  always @(posedge clk) begin
    bus.uart_DO <= rxm[bus.read_ptr[9:0]];
    if (bus.rx_clear) wr <= '0;
    else if (hs_rd < hs_len) begin
      rxm[wr[9:0]] <= hs[hs_rd];
      wr           <= wr + 16'd1;
      hs_rd        <= hs_rd + 1;
    end
  end

  // Output monitors
  int          wr_n = 0, ok_n = 0, err_n = 0, rxc_n = 0, txc_n = 0, tx_n = 0, b2b_n = 0;
  logic [15:0] wr_addr [0:1023];
  logic [7:0]  wr_data [0:1023];
  logic [7:0]  tx_byte [0:63];
  logic [15:0] tx_sp   [0:63];
  logic        prev_we = 1'b0;
  logic [15:0] prev_sp = '0;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr[wr_n] <= bus.mem_addr;
      wr_data[wr_n] <= bus.mem_wdata;
      wr_n          <= wr_n + 1;
    end
    if (bus.mem_we === 1'b1 && prev_we) b2b_n <= b2b_n + 1;
    prev_we <= (bus.mem_we === 1'b1);
    if (bus.frame_ok === 1'b1)  ok_n  <= ok_n + 1;
    if (bus.frame_err === 1'b1) err_n <= err_n + 1;
    if (bus.rx_clear === 1'b1)  rxc_n <= rxc_n + 1;
    if (bus.tx_clear === 1'b1)  txc_n <= txc_n + 1;
    if (bus.send_ptr === prev_sp + 16'd1) begin
      tx_byte[tx_n] <= bus.tx_DI;
      tx_sp[tx_n]   <= bus.send_ptr;
      tx_n          <= tx_n + 1;
    end
    if (!$isunknown(bus.send_ptr)) prev_sp <= bus.send_ptr;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic push_q();
    foreach (fq[i]) begin
      hs[hs_len] = fq[i];
      hs_len++;
    end
    fq.delete();
  endtask

  // Waits for a frame result pulse, then for the loader to sit idle in HUNT
  task automatic wait_result(input int base, input int budget, output bit done);
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ok_n + err_n > base) begin done = 1'b1; break; end
    end
    if (done) begin
      done = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!bus.busy && !bus.rx_clear) begin done = 1'b1; break; end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.send_done = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus.read_ptr, bus.rx_clear, bus.tx_DI, bus.send_ptr, bus.tx_clear, bus.mem_addr, bus.mem_wdata,
                  bus.mem_we, bus.busy, bus.frame_ok, bus.frame_err} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: some output nonzero in reset (busy=%b we=%b rp=%h sp=%h)",
                        bus.busy, bus.mem_we, bus.read_ptr, bus.send_ptr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rx_clear !== 1'b1) begin n_bad++; $display("FAIL reset_rx_clear: got %b want 1", bus.rx_clear); end
    @(negedge clk);
    n_cmp++; if ({bus.rx_clear, bus.busy} !== 2'b00) begin
      n_bad++; $display("FAIL reset_hunt: rx_clear/busy got %b want 00", {bus.rx_clear, bus.busy});
    end
  endtask

  task automatic test_good_frame();
    int w0 = wr_n, t0 = tx_n, c0 = txc_n, o0 = ok_n; bit done;
    fq = '{8'h55, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB, 8'h53};
    push_q();
    wait_result(ok_n + err_n, 2000, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL good_done: no result within budget"); end
    n_cmp++; if (wr_n - w0 !== 2) begin n_bad++; $display("FAIL good_wr_count: got %0d want 2", wr_n - w0); end
    n_cmp++; if ({wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]} !== {16'h1234, 8'hAA, 16'h1235, 8'hBB}) begin
      n_bad++; $display("FAIL good_writes: got %h=%h %h=%h want 1234=AA 1235=BB",
                        wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]);
    end
    n_cmp++; if (ok_n - o0 !== 1) begin n_bad++; $display("FAIL good_frame_ok: got %0d pulses want 1", ok_n - o0); end
    n_cmp++; if (tx_n - t0 !== 1 || tx_byte[t0] !== 8'h06 || tx_sp[t0] !== 16'd1) begin
      n_bad++; $display("FAIL good_reply: n=%0d byte=%h sp=%h want n=1 byte=06 sp=0001", tx_n - t0, tx_byte[t0], tx_sp[t0]);
    end
    n_cmp++; if (txc_n - c0 !== 1 || bus.send_ptr !== 16'd0) begin
      n_bad++; $display("FAIL good_tx_clear: pulses=%0d send_ptr=%h want 1 and 0000", txc_n - c0, bus.send_ptr);
    end
  endtask

  task automatic test_bad_checksum();
    int w0 = wr_n, t0 = tx_n, e0 = err_n, o0 = ok_n; bit done;
    fq = '{8'h55, 8'h00, 8'h10, 8'h01, 8'h5A, 8'h00};
    push_q();
    wait_result(ok_n + err_n, 2000, done);
    n_cmp++; if (!done) begin n_bad++; $display("FAIL bad_done: no result within budget"); end
    n_cmp++; if (wr_n - w0 !== 1 || wr_addr[w0] !== 16'h0010 || wr_data[w0] !== 8'h5A) begin
      n_bad++; $display("FAIL bad_write: n=%0d %h=%h want 1 0010=5A", wr_n - w0, wr_addr[w0], wr_data[w0]);
    end
    n_cmp++; if (err_n - e0 !== 1 || ok_n - o0 !== 0) begin
      n_bad++; $display("FAIL bad_pulses: err=%0d ok=%0d want 1 0", err_n - e0, ok_n - o0);
    end
    n_cmp++; if (tx_n - t0 !== 1 || tx_byte[t0] !== 8'h15) begin
      n_bad++; $display("FAIL bad_reply: n=%0d byte=%h want 1 15", tx_n - t0, tx_byte[t0]);
    end
    // The published vector 55 12 34 02 AA BB 73 sums to 0x20, so it must be NAKed
    t0 = tx_n;
    fq = '{8'h55, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB, 8'h73};
    push_q();
    wait_result(ok_n + err_n, 2000, done);
    n_cmp++; if (!done || tx_n - t0 !== 1 || tx_byte[t0] !== 8'h15) begin
      n_bad++; $display("FAIL bad_chk73: done=%b n=%0d byte=%h want 1 1 15", done, tx_n - t0, tx_byte[t0]);
    end
  endtask

  task automatic test_garbage();
    int w0 = wr_n, r0 = rxc_n, t0 = tx_n; bit done;
    fq = '{8'h00}; push_q();
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rxc_n > r0 && !bus.busy && !bus.rx_clear) begin done = 1'b1; break; end
    end
    fq = '{8'hFF}; push_q();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rxc_n > r0 + 1 && !bus.busy && !bus.rx_clear) break;
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (!done || rxc_n - r0 !== 2 || wr_n - w0 !== 0) begin
      n_bad++; $display("FAIL garbage_clear: clears=%0d writes=%0d want 2 0", rxc_n - r0, wr_n - w0);
    end
    fq = '{8'h55, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB, 8'h53};
    push_q();
    wait_result(ok_n + err_n, 2000, done);
    n_cmp++; if (!done || tx_n - t0 !== 1 || tx_byte[t0] !== 8'h06 || wr_n - w0 !== 2) begin
      n_bad++; $display("FAIL garbage_then_good: n=%0d byte=%h writes=%0d want 1 06 2", tx_n - t0, tx_byte[t0], wr_n - w0);
    end
  endtask

  task automatic test_wrap();
    int w0 = wr_n, t0 = tx_n; bit done;
    fq = '{8'h55, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCD};
    push_q();
    wait_result(ok_n + err_n, 2000, done);
    n_cmp++; if ({wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]} !== {16'hFFFF, 8'h11, 16'h0000, 8'h22}) begin
      n_bad++; $display("FAIL wrap_writes: got %h=%h %h=%h want FFFF=11 0000=22",
                        wr_addr[w0], wr_data[w0], wr_addr[w0+1], wr_data[w0+1]);
    end
    n_cmp++; if (!done || tx_n - t0 !== 1 || tx_byte[t0] !== 8'h06) begin
      n_bad++; $display("FAIL wrap_reply: n=%0d byte=%h want 1 06", tx_n - t0, tx_byte[t0]);
    end
  endtask

  task automatic test_len256();
    int w0 = wr_n, t0 = tx_n, bad = 0; bit done;
    fq.push_back(8'h55); fq.push_back(8'h01); fq.push_back(8'h00); fq.push_back(8'h00);
    for (int i = 0; i < 256; i++) fq.push_back(8'(i));
    fq.push_back(8'h7F);
    push_q();
    wait_result(ok_n + err_n, 5000, done);
    n_cmp++; if (wr_n - w0 !== 256) begin n_bad++; $display("FAIL len256_count: got %0d want 256", wr_n - w0); end
    for (int i = 0; i < 256; i++)
      if (wr_addr[w0+i] !== 16'h0100 + 16'(i) || wr_data[w0+i] !== 8'(i)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL len256_data: %0d wrong writes want 0", bad); end
    n_cmp++; if (!done || tx_n - t0 !== 1 || tx_byte[t0] !== 8'h06) begin
      n_bad++; $display("FAIL len256_reply: n=%0d byte=%h want 1 06", tx_n - t0, tx_byte[t0]);
    end
    n_cmp++; if (b2b_n !== 0) begin n_bad++; $display("FAIL we_spacing: %0d back-to-back strobes want 0", b2b_n); end
  endtask

  task automatic test_timeout();
    int w0 = wr_n, t0 = tx_n, e0 = err_n, o0 = ok_n, el = -1;
    fq = '{8'h55, 8'h12, 8'h34};
    push_q();
    for (int i = 0; i < int'(TO) + 200; i++) begin
      @(negedge clk);
      if (err_n > e0) begin el = i; break; end
    end
    n_cmp++; if (el < int'(TO) || el > int'(TO) + 40) begin
      n_bad++; $display("FAIL timeout_latency: frame_err after %0d clks want %0d..%0d", el, TO, TO + 40);
    end
    repeat (10) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || tx_n - t0 !== 0 || wr_n - w0 !== 0 || ok_n - o0 !== 0) begin
      n_bad++; $display("FAIL timeout_quiet: busy=%b replies=%0d writes=%0d ok=%0d want 0 0 0 0",
                        bus.busy, tx_n - t0, wr_n - w0, ok_n - o0);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_n, t0 = tx_n, c0 = txc_n; bit done;
    bus.send_done = 1'b0;
    fq = '{8'h55, 8'h00, 8'h00, 8'h01, 8'h01, 8'hFE};
    push_q();
    wait_result(ok_n + err_n, 2000, done);
    n_cmp++; if (!done || bus.send_ptr !== 16'd1 || txc_n - c0 !== 0) begin
      n_bad++; $display("FAIL b2b_hold: send_ptr=%h tx_clears=%0d want 0001 0", bus.send_ptr, txc_n - c0);
    end
    bus.send_done = 1'b1;
    fq = '{8'h55, 8'h00, 8'h40, 8'h01, 8'h07, 8'hB8};
    push_q();
    wait_result(ok_n + err_n, 2000, done);
    n_cmp++; if (!done || tx_n - t0 !== 2 || tx_byte[t0+1] !== 8'h06 || tx_sp[t0+1] !== 16'd2) begin
      n_bad++; $display("FAIL b2b_second: n=%0d byte=%h sp=%h want 2 06 0002", tx_n - t0, tx_byte[t0+1], tx_sp[t0+1]);
    end
    n_cmp++; if (bus.send_ptr !== 16'd0 || txc_n - c0 !== 1) begin
      n_bad++; $display("FAIL b2b_drain: send_ptr=%h tx_clears=%0d want 0000 1", bus.send_ptr, txc_n - c0);
    end
    n_cmp++; if (wr_n - w0 !== 2 || wr_addr[w0+1] !== 16'h0040 || wr_data[w0+1] !== 8'h07) begin
      n_bad++; $display("FAIL b2b_write: n=%0d %h=%h want 2 0040=07", wr_n - w0, wr_addr[w0+1], wr_data[w0+1]);
    end
  endtask

  task automatic test_reset_midframe();
    int w0 = wr_n, t0 = tx_n, r0, e0 = err_n, o0 = ok_n; bit seen = 1'b0;
    fq = '{8'h55, 8'h20, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hD6};
    push_q();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_n > w0) begin seen = 1'b1; break; end
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (!seen || {bus.mem_we, bus.busy, bus.read_ptr, bus.send_ptr} !== '0) begin
      n_bad++; $display("FAIL midreset_outputs: seen=%b we=%b busy=%b rp=%h want 1 0 0 0000",
                        seen, bus.mem_we, bus.busy, bus.read_ptr);
    end
    r0 = rxc_n;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rx_clear !== 1'b1) begin n_bad++; $display("FAIL midreset_clear: rx_clear=%b want 1", bus.rx_clear); end
    repeat (60) @(negedge clk);
    n_cmp++; if (wr_n - w0 !== 1 || tx_n - t0 !== 0 || err_n - e0 !== 0 || ok_n - o0 !== 0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_abort: writes=%0d replies=%0d err=%0d ok=%0d busy=%b want 1 0 0 0 0",
                        wr_n - w0, tx_n - t0, err_n - e0, ok_n - o0, bus.busy);
    end
    n_cmp++; if (rxc_n - r0 < 1) begin n_bad++; $display("FAIL midreset_rxc: clears=%0d want >=1", rxc_n - r0); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage();
    test_wrap();
    test_len256();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
